// File: rtl/addsub_seq.sv
// Multicycle NBYTES*8-bit add/subtract sequencer driving one external 8-bit adder slice,
// one byte per cycle LSB first, with the carry chained through an internal register.
module addsub_seq #(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         flag_c,
    output logic         flag_v,
    output logic         flag_z,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_s,
    input  logic         add_c,
    output logic [1:0]   dbg_state
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          cy;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_next;

    assign dbg_state = state;

    // Slice operands come only from registered state, so start/op_* never reach add_*.
    assign add_a   = (state == S_RUN) ? a_q[8*idx +: 8] : 8'd0;
    assign add_b   = (state == S_RUN) ? b_q[8*idx +: 8] : 8'd0;
    assign add_cin = (state == S_RUN) ? cy : 1'b0;

    always_comb begin
        res_next = result;
        res_next[8*idx +: 8] = add_s;
    end

    // Handshake: start is a request taken only in IDLE; busy is high from the cycle
    // after acceptance through the done cycle; done pulses once with result/flags valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            cy     <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= sub ? ~op_b : op_b;
                        cy    <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    result <= res_next;
                    cy     <= add_c;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        flag_c <= add_c;
                        flag_v <= (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
                        flag_z <= (res_next == '0);
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq with NBYTES=4: directed vector table, handshake/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_addsub_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_s;
    logic         add_c;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [W+2:0] exp_q[$];

    addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_c(add_c), .dbg_state(dbg_state)
    );

    // 8-bit slice behaviour: combinational sum and carry-out
    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // reference model: plain unsigned/signed arithmetic on the whole word
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        longint ua, ub, sa, sb, ut, st, smax, smin;
        logic [W-1:0] r;
        logic c, v, z;
        ua = longint'({1'b0, a});
        ub = longint'({1'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (!s) begin
            ut = ua + ub;
            st = sa + sb;
            c  = (ut >= (longint'(1) <<< W));
        end else begin
            ut = ua - ub;
            st = sa - sb;
            c  = (ua >= ub);
        end
        r = ut[W-1:0];
        v = (st > smax) || (st < smin);
        z = (r == '0);
        return {c, v, z, r};
    endfunction

    // scoreboard: every done pops one expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [W+2:0] e;
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done act=%0h exp=none", {flag_c, flag_v, flag_z, result});
            end else begin
                e = exp_q.pop_front();
                if ({flag_c, flag_v, flag_z, result} !== e) begin
                    bad++;
                    $display("FAIL result_flags act=%0h exp=%0h (c,v,z,result)",
                             {flag_c, flag_v, flag_z, result}, e);
                end
            end
        end
    end

    // driver: one operation from IDLE, checking latency, busy length and hold
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W+2:0] e);
        int lat;
        int busy_n;
        bit seen;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; sub = s; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; sub = ~s;
        lat = 0; busy_n = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk("done_latency", 64'(lat), 64'(NBYTES + 1));
        chk("busy_cycles", 64'(busy_n), 64'(NBYTES + 1));
        @(negedge clk);
        chk("done_pulse_busy_fall", {62'd0, done, busy}, 64'd0);
        chk("result_hold", 64'(result), 64'(e[W-1:0]));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        #1;
        chk("reset_outputs", {28'd0, busy, done, flag_c, flag_v, flag_z, result}, 64'd0);
        chk("reset_slice", {47'd0, add_a, add_b, add_cin}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // directed table
        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s,
                   {vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].r});

        // start held through an op with changing operands, then re-accepted after done
        begin
            int n;
            int seen_done_at;
            exp_q.push_back(model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0));
            @(negedge clk);
            start = 1'b1; sub = 1'b0; op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F;
            n = 0; seen_done_at = 0;
            while (seen_done_at == 0 && n < 20) begin
                @(negedge clk);
                n++;
                if (done) seen_done_at = n;
                else begin
                    op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
                end
            end
            chk("hs_first_done_latency", 64'(seen_done_at), 64'(NBYTES + 1));
            op_a = 32'hA5A5_0001; op_b = 32'h0000_0002; sub = 1'b1;
            exp_q.push_back(model(32'hA5A5_0001, 32'h0000_0002, 1'b1));
            @(posedge clk);
            #1;
            chk("hs_idle_after_done", {63'd0, busy}, 64'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("hs_back_to_back_accept", {63'd0, busy}, 64'd1);
            n = 0; seen_done_at = 0;
            while (seen_done_at == 0 && n < 20) begin
                @(negedge clk);
                n++;
                if (done) seen_done_at = n;
            end
            chk("hs_second_done_latency", 64'(seen_done_at), 64'(NBYTES + 1));
            repeat (3) @(negedge clk);
            chk("hs_queue_drained", 64'(exp_q.size()), 64'd0);
        end

        // asynchronous reset in the middle of RUN (idx=2)
        begin
            int saved;
            @(negedge clk);
            start = 1'b1; sub = 1'b0; op_a = 32'h1122_3344; op_b = 32'h0101_0101;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("mid_run_slice_bytes", {48'd0, add_a, add_b}, {48'd0, 8'h22, 8'h01});
            saved = done_cnt;
            rst_n = 1'b0;
            #1;
            chk("midreset_outputs", {28'd0, busy, done, flag_c, flag_v, flag_z, result}, 64'd0);
            chk("midreset_slice", {47'd0, add_a, add_b, add_cin}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (10) @(negedge clk);
            chk("no_done_after_reset", 64'(done_cnt), 64'(saved));
            run_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, model(32'hDEAD_BEEF, 32'h0000_1111, 1'b1));
        end

        // random operations against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] a, b;
            logic s;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = a;
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, model(a, b, s));
        end

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
